// File: rtl/mar_pkg.sv
// Shared types and default sizing for the sequencing memory address register.
package mar_pkg;
  localparam int WIDTH_DEF    = 16;
  localparam int STRIDE_W_DEF = 4;
  localparam int LEN_W_DEF    = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;
endpackage

// File: rtl/mar_seq_if.sv
// Control-unit <-> address register bus; window ports exist only with MAR_BOUNDS_EN.
interface mar_seq_if #(
  parameter int WIDTH    = 16,
  parameter int STRIDE_W = 4,
  parameter int LEN_W    = 8
);
  logic                enI;
  logic [WIDTH-1:0]    data_in;
  logic                inc_en;
  logic [STRIDE_W-1:0] stride;
  logic                burst_start;
  logic [LEN_W-1:0]    burst_len;
  logic [WIDTH-1:0]    data_out;
  logic                burst_busy;
  logic                burst_done;
`ifdef MAR_BOUNDS_EN
  logic [WIDTH-1:0]    win_base;
  logic [WIDTH-1:0]    win_limit;
  logic                bound_err;
`endif

  modport master (
    output enI, data_in, inc_en, stride, burst_start, burst_len,
`ifdef MAR_BOUNDS_EN
    output win_base, win_limit,
    input  bound_err,
`endif
    input  data_out, burst_busy, burst_done
  );

  modport slave (
    input  enI, data_in, inc_en, stride, burst_start, burst_len,
`ifdef MAR_BOUNDS_EN
    input  win_base, win_limit,
    output bound_err,
`endif
    output data_out, burst_busy, burst_done
  );
endinterface

// File: rtl/mar_burst_ctrl.sv
// Burst FSM: length counter, busy level and registered one-cycle done pulse.
module mar_burst_ctrl
  import mar_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             step,
  output logic             capture
);
  state_t           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // A load aborts everything, including a done that would otherwise fire this edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    capture = 1'b0;
    if (load) begin
      state_d = IDLE;
      count_d = '0;
    end else if (state_q == BURST) begin
      count_d = count_q - LEN_W'(1);
      if (count_q == LEN_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      if (len != '0) begin
        capture = 1'b1;
        count_d = len;
        state_d = BURST;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  assign busy = (state_q == BURST);
  assign step = (state_q == BURST) && !load;
  assign done = done_q;
endmodule

// File: rtl/mar_seq.sv
// Memory address register with load, stride increment and autonomous bursts.
// MAR_BOUNDS_EN adds a base/limit window that redirects overruns to win_base.
module mar_seq
  import mar_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int STRIDE_W = STRIDE_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic    clk,
  input  logic    reset,
  mar_seq_if.slave bus
);
  logic [WIDTH-1:0]    addr_q;
  logic [STRIDE_W-1:0] stride_q;
  logic [STRIDE_W-1:0] step_val;
  logic [WIDTH-1:0]    addr_inc;
  logic                busy, step, capture, do_inc;

  mar_burst_ctrl #(.LEN_W(LEN_W)) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .load    (bus.enI),
    .start   (bus.burst_start),
    .len     (bus.burst_len),
    .busy    (busy),
    .done    (bus.burst_done),
    .step    (step),
    .capture (capture)
  );

  // Single increments are only honoured in IDLE and lose to a burst_start.
  assign do_inc   = !bus.enI && (step || (!busy && !bus.burst_start && bus.inc_en));
  assign step_val = busy ? stride_q : bus.stride;

`ifdef MAR_BOUNDS_EN
  logic [WIDTH:0] sum;
  logic           over;
  logic           err_q;

  // Compare on WIDTH+1 bits so a carry out also counts as an overrun.
  assign sum      = {1'b0, addr_q} + (WIDTH+1)'(step_val);
  assign over     = sum > {1'b0, bus.win_limit};
  assign addr_inc = over ? bus.win_base : sum[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (bus.enI) begin
      err_q <= 1'b0;
    end else if (do_inc && over) begin
      err_q <= 1'b1;
    end
  end

  assign bus.bound_err = err_q;
`else
  assign addr_inc = addr_q + WIDTH'(step_val);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      if (bus.enI) begin
        addr_q <= bus.data_in;
      end else if (do_inc) begin
        addr_q <= addr_inc;
      end
      if (capture) begin
        stride_q <= bus.stride;
      end
    end
  end

  assign bus.data_out   = addr_q;
  assign bus.burst_busy = busy;
endmodule

// File: doc/mar_seq.md
# mar_seq

Parametrised successor to the 16-bit memory address register: holds the current memory address and, besides parallel load, supports single-step increment by a programmable stride and autonomous fixed-length bursts. Sits between the control unit and the memory interface in the datapath, driving the address bus for sequential fetch/DMA-style transfers without control-unit involvement per beat.

## Interface
- WIDTH, 16, address width in bits
- STRIDE_W, 4, width of the stride operand (unsigned, zero-extended to WIDTH)
- LEN_W, 8, width of the burst length operand
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- enI  in  1  parallel load enable
- data_in  in  WIDTH  load value
- inc_en  in  1  single increment by stride (idle only)
- stride  in  STRIDE_W  increment step
- burst_start  in  1  start burst (idle only)
- burst_len  in  LEN_W  number of burst increments
- data_out  out  WIDTH  current address
- burst_busy  out  1  high while in BURST
- burst_done  out  1  one-cycle pulse on burst completion
- win_base, win_limit  in  WIDTH  address window (MAR_BOUNDS_EN only)
- bound_err  out  1  sticky window-overrun flag (MAR_BOUNDS_EN only)

## Operation
- Reset (reset low, asynchronous): data_out=0, state IDLE, burst_busy=0, burst_done=0, count=0, bound_err=0.
- States: IDLE, BURST. burst_busy = (state==BURST).
- Per-edge priority: enI load > BURST step > IDLE burst_start > IDLE inc_en > hold.
- enI=1: data_out<=data_in; any burst aborted (state IDLE, count cleared, no burst_done); clears bound_err.
- IDLE, burst_start=1, burst_len!=0: capture stride into stride_q, count<=burst_len, go BURST; address unchanged this edge.
- IDLE, burst_start=1, burst_len==0: no state change, burst_done pulses next cycle.
- IDLE, inc_en=1 (no burst_start): data_out<=data_out+stride.
- BURST each edge: data_out<=data_out+stride_q; count--; when count==1, go IDLE, burst_done<=1.
- burst_start and inc_en ignored in BURST; stride changes mid-burst ignored.
- Arithmetic unsigned, modulo 2^WIDTH (natural wrap 0xFFFF+1 -> 0x0000 at WIDTH=16). stride=0 legal: address holds, count still runs.

## Timing
- Load and increment: 1-cycle latency, data_out valid after the edge.
- burst_start sampled at edge T: burst_busy high after T; increments at edges T+1..T+len; burst_busy low and burst_done high after edge T+len, for exactly one cycle.
- New burst_start accepted in the cycle burst_done is high (back-to-back, no gap).
- reset asserted mid-burst: immediate return to reset values, no burst_done.

## Configuration
- MAR_BOUNDS_EN defined: win_base, win_limit, bound_err ports exist. Any increment (inc_en or burst step) whose result (computed on WIDTH+1 bits) exceeds win_limit loads win_base instead and sets bound_err; bound_err sticky until enI load or reset. Burst continues from win_base.
- Not defined: ports absent, only natural modulo-2^WIDTH wrap.

## Structure
- mar_pkg: state enum (IDLE, BURST), default WIDTH/STRIDE_W/LEN_W constants.
- One sub-module: mar_burst_ctrl (FSM, length counter, burst_done/burst_busy generation); address register and adder in mar_seq.

## Test plan
- Reset low mid-operation -> data_out=0x0000, burst_busy=0, burst_done=0 immediately, no clock needed.
- enI=1, data_in=0x1234 -> data_out=0x1234 next cycle; inc_en=1, stride=4 -> 0x1238.
- Load 0x0100, burst_start, burst_len=3, stride=2 -> 0x0102, 0x0104, 0x0106 on successive cycles, burst_done one cycle after last, busy 3 cycles.
- Load 0xFFFE, inc_en, stride=3 -> 0x0001 (macro off); burst with enI=1 at second beat, data_in=0x0020 -> data_out=0x0020, busy drops, no burst_done.
- burst_len=0 -> burst_done one cycle, busy never high, address unchanged.
- MAR_BOUNDS_EN: win_base=0x1000, win_limit=0x100F, load 0x100E, inc stride=4 -> 0x1000, bound_err=1 until next load.
